cmd_phy_txrx: RTL and testbench

Physical-layer engine of the SD host CMD line, directly downstream of `cmd_control`. It accepts the 40-bit command frame that `cmd_control` presents with `strobe_out`, appends CRC7 and the end bit, and serializes 48 bits MSB-first onto the CMD pad. It then waits for and deserializes the card response (none, 48-bit or 136-bit), checks it, and returns it to `cmd_control` with a strobe/ack handshake. It runs entirely in the SD clock domain and drives `cmd_PAD_card`.

---
 rtl/cmd_phy_pkg.sv | 36 +++
 rtl/cmd_phy_txrx_if.sv | 24 ++
 rtl/crc7_serial.sv | 31 +++
 rtl/cmd_phy_txrx.sv | 203 ++++++++++++++++++++
 tb/tb_cmd_phy_txrx.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/cmd_phy_pkg.sv
// Shared definitions for the SD CMD-line PHY: FSM encoding, response
// type codes, frame lengths and the CRC7 single-bit update step.
package cmd_phy_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        RESP_NONE      = 2'b00,
        RESP_R48       = 2'b01,
        RESP_R136      = 2'b10,
        RESP_R48_NOCRC = 2'b11
    } resp_t;

    localparam int CMD_LEN    = 48;   // full serial command frame
    localparam int CMD_BODY   = 40;   // start/tx/index/argument, covered by CRC
    localparam int RESP_SHORT = 48;
    localparam int RESP_LONG  = 136;
    localparam int LONG_CRC_LO = 8;   // R2 CRC covers [127:8]; first 8 bits skipped
    localparam int LONG_CRC_HI = 128;

    localparam logic [6:0] CRC7_POLY = 7'h09;   // x^7 + x^3 + 1

    // One shift of the CRC7 register with a new message bit.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/cmd_phy_txrx_if.sv
// Handshake bundle between cmd_control (master) and the CMD PHY (slave).
interface cmd_phy_txrx_if;
    import cmd_phy_pkg::*;

    logic                 strobe_in;
    logic [CMD_BODY-1:0]  cmd_in;
    logic [1:0]           resp_type;
    logic                 ack_in;
    logic                 strobe_out;
    logic                 idle_out;
    logic [RESP_LONG-1:0] response;
    logic                 crc_err;
    logic                 timeout_err;

    modport master (
        output strobe_in, cmd_in, resp_type, ack_in,
        input  strobe_out, idle_out, response, crc_err, timeout_err
    );

    modport slave (
        input  strobe_in, cmd_in, resp_type, ack_in,
        output strobe_out, idle_out, response, crc_err, timeout_err
    );
endinterface

// File: rtl/crc7_serial.sv
// Bit-serial CRC7 accumulator. Clear together with enable starts a new
// CRC from the presented bit, so the first bit is not lost.
module crc7_serial
    import cmd_phy_pkg::*;
(
    input  logic       clk_SD,
    input  logic       reset_host,
    input  logic       i_clear,
    input  logic       i_enable,
    input  logic       i_bit,
    output logic [6:0] o_crc
);

    logic [6:0] r_crc;
    logic [6:0] w_base;

    assign w_base = i_clear ? 7'h00 : r_crc;
    assign o_crc  = r_crc;

    // Accumulate one message bit per enabled cycle.
    always_ff @(posedge clk_SD or posedge reset_host) begin
        if (reset_host) begin
            r_crc <= 7'h00;
        end else if (i_enable) begin
            r_crc <= crc7_step(w_base, i_bit);
        end else if (i_clear) begin
            r_crc <= 7'h00;
        end
    end

endmodule

// File: rtl/cmd_phy_txrx.sv
// SD host CMD-line PHY: serializes a 40-bit command plus CRC7 and end bit,
// then waits for and deserializes the card response and checks it.
module cmd_phy_txrx
    import cmd_phy_pkg::*;
#(
    parameter int TIMEOUT = 64
) (
    input  logic           clk_SD,
    input  logic           reset_host,
    cmd_phy_txrx_if.slave  ctrl,
    input  logic           IOin_SD,
    output logic           IOout_SD,
    output logic           cmd_oe
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_t               r_state;
    resp_t                r_resp_type;
    logic [CMD_BODY-1:0]  r_tx_sr;
    logic [7:0]           r_bit_cnt;
    logic [WCNT_W-1:0]    r_wait_cnt;
    logic                 r_io_out;
    logic                 r_oe;
    logic                 r_strobe;
    logic                 r_idle;
    logic [RESP_LONG-1:0] r_resp;
    logic                 r_crc_err;
    logic                 r_timeout_err;

    logic                 w_crc_clr;
    logic                 w_crc_en;
    logic                 w_crc_bit;
    logic [6:0]           w_crc;
    logic [7:0]           w_bit_next;
    logic [7:0]           w_rx_last;
    logic                 w_is_long;

    assign IOout_SD         = r_io_out;
    assign cmd_oe           = r_oe;
    assign ctrl.strobe_out  = r_strobe;
    assign ctrl.idle_out    = r_idle;
    assign ctrl.response    = r_resp;
    assign ctrl.crc_err     = r_crc_err;
    assign ctrl.timeout_err = r_timeout_err;

    // The bit counter saturates instead of wrapping.
    assign w_bit_next = (r_bit_cnt == 8'hFF) ? 8'hFF : r_bit_cnt + 8'd1;
    assign w_is_long  = (r_resp_type == RESP_R136);
    assign w_rx_last  = w_is_long ? 8'(RESP_LONG - 1) : 8'(RESP_SHORT - 1);

    // One CRC engine serves TX then RX; pick its feed from the current phase.
    always_comb begin
        w_crc_clr = 1'b0;
        w_crc_en  = 1'b0;
        w_crc_bit = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_crc_clr = ctrl.strobe_in;
                w_crc_en  = ctrl.strobe_in;
                w_crc_bit = ctrl.cmd_in[CMD_BODY-1];
            end
            ST_SEND: begin
                if (r_bit_cnt == 8'(CMD_LEN - 1)) begin
                    w_crc_clr = (r_resp_type != RESP_NONE);
                end else begin
                    w_crc_en  = (w_bit_next < 8'(CMD_BODY));
                    w_crc_bit = r_tx_sr[CMD_BODY-1];
                end
            end
            ST_WAIT: begin
                // Start bit is response bit 0; only short frames cover it.
                w_crc_en  = !IOin_SD && !w_is_long;
                w_crc_bit = IOin_SD;
            end
            ST_RECV: begin
                w_crc_bit = IOin_SD;
                if (w_is_long) begin
                    w_crc_en = (r_bit_cnt >= 8'(LONG_CRC_LO)) && (r_bit_cnt < 8'(LONG_CRC_HI));
                end else begin
                    w_crc_en = (r_bit_cnt < 8'(CMD_BODY));
                end
            end
            default: begin
                w_crc_en = 1'b0;
            end
        endcase
    end

    crc7_serial u_crc7 (
        .clk_SD     (clk_SD),
        .reset_host (reset_host),
        .i_clear    (w_crc_clr),
        .i_enable   (w_crc_en),
        .i_bit      (w_crc_bit),
        .o_crc      (w_crc)
    );

    // Main transaction FSM with registered pad and handshake outputs.
    always_ff @(posedge clk_SD or posedge reset_host) begin
        if (reset_host) begin
            r_state       <= ST_IDLE;
            r_resp_type   <= RESP_NONE;
            r_tx_sr       <= '0;
            r_bit_cnt     <= '0;
            r_wait_cnt    <= '0;
            r_io_out      <= 1'b1;
            r_oe          <= 1'b0;
            r_strobe      <= 1'b0;
            r_idle        <= 1'b1;
            r_resp        <= '0;
            r_crc_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_io_out <= 1'b1;
                    r_oe     <= 1'b0;
                    r_idle   <= 1'b1;
                    if (ctrl.strobe_in) begin
                        r_resp_type   <= resp_t'(ctrl.resp_type);
                        // First bit goes straight to the pad; the rest queue up.
                        r_io_out      <= ctrl.cmd_in[CMD_BODY-1];
                        r_tx_sr       <= {ctrl.cmd_in[CMD_BODY-2:0], 1'b0};
                        r_oe          <= 1'b1;
                        r_idle        <= 1'b0;
                        r_bit_cnt     <= '0;
                        r_wait_cnt    <= '0;
                        r_resp        <= '0;
                        r_crc_err     <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_state       <= ST_SEND;
                    end
                end

                ST_SEND: begin
                    if (r_bit_cnt == 8'(CMD_LEN - 1)) begin
                        r_io_out   <= 1'b1;
                        r_oe       <= 1'b0;
                        r_bit_cnt  <= '0;
                        r_wait_cnt <= '0;
                        if (r_resp_type == RESP_NONE) begin
                            r_strobe <= 1'b1;
                            r_state  <= ST_DONE;
                        end else begin
                            r_state  <= ST_WAIT;
                        end
                    end else begin
                        r_bit_cnt <= w_bit_next;
                        if (w_bit_next == 8'(CMD_BODY)) begin
                            // Body done: reload the shifter with CRC[5:0] and the end bit.
                            r_io_out <= w_crc[6];
                            r_tx_sr  <= {w_crc[5:0], 1'b1, {(CMD_BODY-7){1'b0}}};
                        end else begin
                            r_io_out <= r_tx_sr[CMD_BODY-1];
                            r_tx_sr  <= {r_tx_sr[CMD_BODY-2:0], 1'b0};
                        end
                    end
                end

                ST_WAIT: begin
                    if (!IOin_SD) begin
                        r_resp    <= {r_resp[RESP_LONG-2:0], IOin_SD};
                        r_bit_cnt <= 8'd1;
                        r_state   <= ST_RECV;
                    end else if (r_wait_cnt == WCNT_W'(TIMEOUT - 1)) begin
                        r_timeout_err <= 1'b1;
                        r_strobe      <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end

                ST_RECV: begin
                    r_resp <= {r_resp[RESP_LONG-2:0], IOin_SD};
                    if (r_bit_cnt == w_rx_last) begin
                        // Received CRC field sits in r_resp[6:0] before this final shift.
                        r_crc_err <= !IOin_SD ||
                                     ((r_resp_type != RESP_R48_NOCRC) && (w_crc != r_resp[6:0]));
                        r_strobe  <= 1'b1;
                        r_state   <= ST_DONE;
                    end else begin
                        r_bit_cnt <= w_bit_next;
                    end
                end

                ST_DONE: begin
                    if (ctrl.ack_in) begin
                        r_strobe <= 1'b0;
                        r_idle   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_phy_txrx.sv
// Directed bench for cmd_phy_txrx: known SD command frames with
// hand-computed CRC bytes, card responses built with a CRC7 model.
module tb_cmd_phy_txrx;

    localparam int TO = 64;

    logic clk_SD     = 1'b0;
    logic reset_host = 1'b1;
    logic IOin_SD    = 1'b1;
    logic IOout_SD;
    logic cmd_oe;

    int n_total = 0;
    int n_bad   = 0;

    cmd_phy_txrx_if bus();

    cmd_phy_txrx #(.TIMEOUT(TO)) dut (
        .clk_SD     (clk_SD),
        .reset_host (reset_host),
        .ctrl       (bus),
        .IOin_SD    (IOin_SD),
        .IOout_SD   (IOout_SD),
        .cmd_oe     (cmd_oe)
    );

    always #5 clk_SD = ~clk_SD;

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [135:0] act, input logic [135:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    function automatic logic [6:0] crc7_calc(input logic [119:0] d, input int n);
        logic [6:0] c;
        logic       fb;
        c = 7'h00;
        for (int i = n - 1; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return c;
    endfunction

    // One full command: send, capture serial, answer (or not), ack.
    // rt==00 -> no response; rsp_len==0 -> line held high (timeout).
    task automatic run_txn(input string name, input logic [39:0] cmd, input logic [1:0] rt,
                           input logic [47:0] exp_ser, input logic [135:0] rsp, input int rsp_len,
                           input int gap, input logic exp_crc, input logic exp_to, input int ack_gap);
        logic [47:0] ser;
        int          n;
        @(negedge clk_SD);
        bus.strobe_in = 1'b1;
        bus.cmd_in    = cmd;
        bus.resp_type = rt;
        @(negedge clk_SD);
        bus.strobe_in = 1'b0;
        bus.cmd_in    = ~cmd;
        bus.ack_in    = 1'b1;            // must be ignored while sending
        chk({name, "/idle_low"}, 136'(bus.idle_out), 136'(0));
        chk({name, "/oe_on"}, 136'(cmd_oe), 136'(1));
        ser[47] = IOout_SD;
        for (int i = 46; i >= 0; i--) begin
            @(negedge clk_SD);
            ser[i] = IOout_SD;
        end
        bus.ack_in = 1'b0;
        chk({name, "/serial"}, 136'(ser), 136'(exp_ser));
        if (rt == 2'b00) begin
            @(negedge clk_SD);
            chk({name, "/strobe"}, 136'(bus.strobe_out), 136'(1));
        end else if (rsp_len == 0) begin
            n = 0;
            do begin
                @(negedge clk_SD);
                n++;
            end while (!bus.strobe_out && n < TO + 20);
            chk({name, "/to_latency"}, 136'(n), 136'(TO + 1));
            chk({name, "/oe_off"}, 136'(cmd_oe), 136'(0));
        end else begin
            for (int i = 0; i < gap; i++) begin
                @(negedge clk_SD);
                IOin_SD       = 1'b1;
                bus.strobe_in = 1'b1;    // must be ignored while waiting
            end
            if (gap > 0) chk({name, "/oe_wait"}, 136'(cmd_oe), 136'(0));
            for (int i = rsp_len - 1; i >= 0; i--) begin
                @(negedge clk_SD);
                bus.strobe_in = 1'b0;
                IOin_SD       = rsp[i];
            end
            @(negedge clk_SD);
            IOin_SD = 1'b1;
            chk({name, "/strobe"}, 136'(bus.strobe_out), 136'(1));
        end
        chk({name, "/response"}, bus.response, rsp);
        chk({name, "/crc_err"}, 136'(bus.crc_err), 136'(exp_crc));
        chk({name, "/timeout_err"}, 136'(bus.timeout_err), 136'(exp_to));
        for (int j = 0; j < ack_gap; j++) begin
            @(negedge clk_SD);
            chk({name, "/strobe_hold"}, 136'(bus.strobe_out), 136'(1));
        end
        bus.ack_in = 1'b1;
        @(negedge clk_SD);
        bus.ack_in = 1'b0;
        chk({name, "/strobe_fall"}, 136'(bus.strobe_out), 136'(0));
        chk({name, "/idle_back"}, 136'(bus.idle_out), 136'(1));
        chk({name, "/crc_kept"}, 136'(bus.crc_err), 136'(exp_crc));
        $display("txn %s: ser=%h resp=%h crc_err=%b timeout_err=%b",
                 name, ser, bus.response, bus.crc_err, bus.timeout_err);
    endtask

    logic [47:0]  r7;
    logic [47:0]  r1;
    logic [119:0] cid;
    logic [135:0] r2;

    initial begin
        bus.strobe_in = 1'b0;
        bus.cmd_in    = '0;
        bus.resp_type = 2'b00;
        bus.ack_in    = 1'b0;
        repeat (3) @(negedge clk_SD);
        chk("rst/io", 136'(IOout_SD), 136'(1));
        chk("rst/oe", 136'(cmd_oe), 136'(0));
        chk("rst/strobe", 136'(bus.strobe_out), 136'(0));
        chk("rst/idle", 136'(bus.idle_out), 136'(1));
        chk("rst/response", bus.response, 136'(0));
        chk("rst/flags", 136'({bus.crc_err, bus.timeout_err}), 136'(0));
        reset_host = 1'b0;
        @(negedge clk_SD);

        run_txn("CMD0", 40'h40_0000_0000, 2'b00, 48'h40_0000_0000_95, 136'(0), 0, 0, 1'b0, 1'b0, 2);

        r7 = {40'h08_0000_01AA, crc7_calc({80'd0, 40'h08_0000_01AA}, 40), 1'b1};
        run_txn("CMD8", 40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87, 136'(r7), 48, 5, 1'b0, 1'b0, 1);
        run_txn("CMD8_flip", 40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87,
                136'(r7 ^ (48'h1 << 20)), 48, 5, 1'b1, 1'b0, 0);

        cid = 120'h035344534431364780123456780148;
        r2  = {8'h3F, cid, crc7_calc(cid, 120), 1'b1};
        run_txn("CMD2", 40'h42_0000_0000, 2'b10, 48'h42_0000_0000_4D, r2, 136, 3, 1'b0, 1'b0, 10);

        run_txn("CMD8_timeout", 40'h48_0000_01AA, 2'b01, 48'h48_0000_01AA_87, 136'(0), 0, 0, 1'b0, 1'b1, 1);

        // R3 carries all-ones in the CRC field; only the end bit is checked.
        run_txn("CMD58", 40'h7A_0000_0000, 2'b11, 48'h7A_0000_0000_FD, 136'(48'h3F_80FF_8000_FF), 48, 2,
                1'b0, 1'b0, 0);

        r1 = {40'h37_0000_0120, crc7_calc({80'd0, 40'h37_0000_0120}, 40), 1'b0};
        run_txn("CMD55_endbit", 40'h77_0000_0000, 2'b01, 48'h77_0000_0000_65, 136'(r1), 48, 1, 1'b1, 1'b0, 0);

        // Reset mid-frame: abort at bit 20, then a clean command follows.
        @(negedge clk_SD);
        bus.strobe_in = 1'b1;
        bus.cmd_in    = 40'h77_0000_0000;
        bus.resp_type = 2'b01;
        @(negedge clk_SD);
        bus.strobe_in = 1'b0;
        repeat (20) @(negedge clk_SD);
        chk("abort/oe_before", 136'(cmd_oe), 136'(1));
        reset_host = 1'b1;
        @(negedge clk_SD);
        chk("abort/io", 136'(IOout_SD), 136'(1));
        chk("abort/oe", 136'(cmd_oe), 136'(0));
        chk("abort/idle", 136'(bus.idle_out), 136'(1));
        chk("abort/strobe", 136'(bus.strobe_out), 136'(0));
        reset_host = 1'b0;
        $display("txn abort: reset at bit 20 io=%b oe=%b idle=%b", IOout_SD, cmd_oe, bus.idle_out);

        run_txn("CMD0_after_rst", 40'h40_0000_0000, 2'b00, 48'h40_0000_0000_95, 136'(0), 0, 0, 1'b0, 1'b0, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
